cpu_step_clock: RTL and testbench

- Generates the single-cycle CPU advance enable (`cpu_tick`) from board push-buttons. Replaces the raw debounced-button clock that feeds the register bank and microcode.
- Two modes:
  - Step mode: one tick per debounced press of the step button.
  - Run mode: free-running ticks at a switch-selected power-of-two rate.
- Tracks the fetch/exec phase so the control logic and LEDs get a registered phase without a separate toggle flop.
- All logic runs on the board clock. Downstream registers use `cpu_tick` as a clock enable, not as a clock.

---
 rtl/cpu_clk_pkg.sv | 19 +
 rtl/button_debounce.sv | 59 +++++
 rtl/cpu_step_clock.sv | 138 +++++++++++++
 tb/tb_cpu_step_clock.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_clk_pkg.sv
// ============================================================================
//  Module      : cpu_clk_pkg
//  Description : Shared defaults and phase encoding for the CPU step clock,
//                the microcode sequencer and the control logic.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_clk_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int DEFAULT_DIV_BASE_LOG2   = 16;

    localparam logic PHASE_FETCH = 1'b0;
    localparam logic PHASE_EXEC  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/button_debounce.sv
// ============================================================================
//  Module      : button_debounce
//  Description : Two-flop synchroniser, stable-count debouncer and a one-cycle
//                pulse on each debounced rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debounce
    import cpu_clk_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam int                 c_cnt_w  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_last   = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic [1:0]         r_sync;
    logic               r_level;
    logic               r_level_d;
    logic               r_press;
    logic [c_cnt_w-1:0] r_cnt;

    // Levels reset to "pressed" so a button held through reset needs a
    // full release/press cycle before it can produce a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync    <= 2'b11;
            r_level   <= 1'b1;
            r_level_d <= 1'b1;
            r_press   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync    <= {r_sync[0], btn_raw};
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d;
            if (r_sync[1] != r_level) begin
                if (r_cnt == c_last) begin
                    r_level <= ~r_level;
                    r_cnt   <= '0;
                end else begin
                    r_cnt   <= r_cnt + c_cnt_w'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign press = r_press;

endmodule

`default_nettype wire

// File: rtl/cpu_step_clock.sv
// ============================================================================
//  Module      : cpu_step_clock
//  Description : CPU advance enable from step/run buttons with a power-of-two
//                run rate; optional breakpoint halt under CPU_BREAK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_step_clock
    import cpu_clk_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int DIV_BASE_LOG2   = DEFAULT_DIV_BASE_LOG2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_step,
    input  logic        btn_run,
    input  logic [2:0]  rate_sel,
`ifdef CPU_BREAK_EN
    input  logic [15:0] pc,
    input  logic [15:0] bkpt_addr,
    input  logic        bkpt_valid,
    output logic        halted,
`endif
    output logic        cpu_tick,
    output logic        phase,
    output logic        running
);

    localparam int DIV_W = DIV_BASE_LOG2 + 8;

    logic             w_step_press;
    logic             w_run_press;
    logic [DIV_W-1:0] w_terminal;
    logic             w_tick_nxt;
    logic             w_running_nxt;
    logic [DIV_W-1:0] w_div_nxt;

    logic             r_tick;
    logic             r_phase;
    logic             r_running;
    logic [DIV_W-1:0] r_div;

`ifdef CPU_BREAK_EN
    logic             w_bkpt_hit;
    logic             r_halted;
`endif

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_step),
        .press   (w_step_press)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_run),
        .press   (w_run_press)
    );

    assign w_terminal = (DIV_W'(1) << (DIV_BASE_LOG2 + int'(rate_sel))) - DIV_W'(1);

    // A run press takes priority over both the divider wrap and a step press.
    always_comb begin
        w_tick_nxt    = 1'b0;
        w_running_nxt = r_running;
        w_div_nxt     = r_div;
`ifdef CPU_BREAK_EN
        w_bkpt_hit    = 1'b0;
`endif
        if (w_run_press) begin
            w_running_nxt = ~r_running;
            if (!r_running) begin
                w_div_nxt = '0;
            end
        end else if (r_running) begin
            // >= rather than == so a shortened period wraps at once.
            if (r_div >= w_terminal) begin
                w_div_nxt = '0;
`ifdef CPU_BREAK_EN
                if (r_phase == PHASE_FETCH && bkpt_valid && pc == bkpt_addr) begin
                    w_bkpt_hit    = 1'b1;
                    w_running_nxt = 1'b0;
                end else begin
                    w_tick_nxt = 1'b1;
                end
`else
                w_tick_nxt = 1'b1;
`endif
            end else begin
                w_div_nxt = r_div + DIV_W'(1);
            end
        end else if (w_step_press) begin
            w_tick_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick    <= 1'b0;
            r_phase   <= PHASE_FETCH;
            r_running <= 1'b0;
            r_div     <= '0;
        end else begin
            // Never two ticks back to back, even with a one-cycle period.
            r_tick    <= w_tick_nxt & ~r_tick;
            r_running <= w_running_nxt;
            r_div     <= w_div_nxt;
            if (r_tick) begin
                r_phase <= ~r_phase;
            end
        end
    end

`ifdef CPU_BREAK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_halted <= 1'b0;
        end else if (w_bkpt_hit) begin
            r_halted <= 1'b1;
        end else if (w_run_press || w_step_press) begin
            r_halted <= 1'b0;
        end
    end

    assign halted = r_halted;
`endif

    assign cpu_tick = r_tick;
    assign phase    = r_phase;
    assign running  = r_running;

endmodule

`default_nettype wire

// File: tb/tb_cpu_step_clock.sv
// ============================================================================
//  Module      : tb_cpu_step_clock
//  Description : Directed self-checking bench for cpu_step_clock
//                (DEBOUNCE_CYCLES=4, DIV_BASE_LOG2=2).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_step_clock;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_step;
    logic        btn_run;
    logic [2:0]  rate_sel;
    logic        cpu_tick;
    logic        phase;
    logic        running;
`ifdef CPU_BREAK_EN
    logic [15:0] pc;
    logic [15:0] bkpt_addr;
    logic        bkpt_valid;
    logic        halted;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cpu_step_clock #(
        .DEBOUNCE_CYCLES (4),
        .DIV_BASE_LOG2   (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_step   (btn_step),
        .btn_run    (btn_run),
        .rate_sel   (rate_sel),
`ifdef CPU_BREAK_EN
        .pc         (pc),
        .bkpt_addr  (bkpt_addr),
        .bkpt_valid (bkpt_valid),
        .halted     (halted),
`endif
        .cpu_tick   (cpu_tick),
        .phase      (phase),
        .running    (running)
    );

    // Advance one clock; inputs set afterwards are seen at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, output int ticks);
        ticks = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (cpu_tick === 1'b1) ticks++;
        end
    endtask

    // Cycles until cpu_tick is seen, or -1 if the budget runs out.
    task automatic wait_tick(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            step();
            if (cpu_tick === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_running(input logic want, input int max,
                                output int n, output int ticks);
        n = -1;
        ticks = 0;
        for (int i = 1; i <= max; i++) begin
            step();
            if (cpu_tick === 1'b1) ticks++;
            if (running === want) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; btn_step = 1'b1; btn_run = 1'b0; rate_sel = 3'd0;
        repeat (3) step();
        n_vec++;
        if (cpu_tick !== 1'b0) begin n_err++; $display("FAIL reset_tick: got %b want 0", cpu_tick); end
        n_vec++;
        if (phase !== 1'b0) begin n_err++; $display("FAIL reset_phase: got %b want 0", phase); end
        n_vec++;
        if (running !== 1'b0) begin n_err++; $display("FAIL reset_running: got %b want 0", running); end
`ifdef CPU_BREAK_EN
        n_vec++;
        if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b want 0", halted); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_held_through_reset();
        int t;
        idle(10, t);
        n_vec++;
        if (t !== 0) begin n_err++; $display("FAIL held_no_tick: got %0d ticks want 0", t); end
        btn_step = 1'b0;
        idle(10, t);
        n_vec++;
        if (t !== 0) begin n_err++; $display("FAIL release_no_tick: got %0d ticks want 0", t); end
        btn_step = 1'b1;
        idle(7, t);
        n_vec++;
        if (t !== 0) begin n_err++; $display("FAIL press_early_tick: got %0d ticks want 0", t); end
        step();
        n_vec++;
        if (cpu_tick !== 1'b1 || phase !== 1'b0) begin
            n_err++; $display("FAIL press_tick_at_7: got tick=%b phase=%b want tick=1 phase=0", cpu_tick, phase);
        end
        step();
        n_vec++;
        if (cpu_tick !== 1'b0 || phase !== 1'b1) begin
            n_err++; $display("FAIL press_after_tick: got tick=%b phase=%b want tick=0 phase=1", cpu_tick, phase);
        end
    endtask

    task automatic test_bounce();
        int t;
        btn_step = 1'b0;
        idle(10, t);
        for (int i = 0; i < 10; i++) begin
            btn_step = (i % 2 == 0) ? 1'b1 : 1'b0;
            step();
            if (cpu_tick === 1'b1) t++;
        end
        btn_step = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (cpu_tick === 1'b1) t++;
        end
        n_vec++;
        if (t !== 1) begin n_err++; $display("FAIL bounce_ticks: got %0d want 1", t); end
        n_vec++;
        if (phase !== 1'b0) begin n_err++; $display("FAIL bounce_phase: got %b want 0", phase); end
    endtask

    task automatic test_run_rates();
        int n;
        int t;
        btn_step = 1'b0; btn_run = 1'b0; rate_sel = 3'd0;
        idle(10, t);
        btn_run = 1'b1;
        wait_running(1'b1, 20, n, t);
        n_vec++;
        if (n !== 8 || t !== 0) begin n_err++; $display("FAIL run_enter: got cycles=%0d ticks=%0d want 8/0", n, t); end
        for (int k = 0; k < 2; k++) begin
            wait_tick(20, n);
            n_vec++;
            if (n !== 4) begin n_err++; $display("FAIL rate0_period%0d: got %0d want 4", k, n); end
        end
        rate_sel = 3'd1;
        for (int k = 0; k < 2; k++) begin
            wait_tick(20, n);
            n_vec++;
            if (n !== 8) begin n_err++; $display("FAIL rate1_period%0d: got %0d want 8", k, n); end
        end
        rate_sel = 3'd3;
        idle(20, t);
        n_vec++;
        if (t !== 0) begin n_err++; $display("FAIL rate3_count20: got %0d ticks want 0", t); end
        rate_sel = 3'd0;
        wait_tick(5, n);
        n_vec++;
        if (n !== 1) begin n_err++; $display("FAIL rate_shrink_wrap: got %0d want 1", n); end
        btn_run = 1'b0;
        idle(10, t);
        btn_run = 1'b1;
        wait_running(1'b0, 20, n, t);
        n_vec++;
        if (n !== 8) begin n_err++; $display("FAIL run_leave: got %0d want 8", n); end
        idle(12, t);
        n_vec++;
        if (t !== 0) begin n_err++; $display("FAIL after_leave_ticks: got %0d want 0", t); end
        btn_run = 1'b0;
        idle(10, t);
    endtask

    task automatic test_simultaneous();
        int   n;
        int   t;
        logic ph;
        ph = phase;
        btn_run = 1'b1; btn_step = 1'b1;
        wait_running(1'b1, 20, n, t);
        n_vec++;
        if (n !== 8 || t !== 0) begin n_err++; $display("FAIL simul_enter: got cycles=%0d ticks=%0d want 8/0", n, t); end
        n_vec++;
        if (phase !== ph) begin n_err++; $display("FAIL simul_phase: got %b want %b", phase, ph); end
        wait_tick(20, n);
        n_vec++;
        if (n !== 4) begin n_err++; $display("FAIL simul_first_tick: got %0d want 4", n); end
    endtask

    task automatic test_reset_mid_run();
        int n;
        int t;
        wait_tick(20, n);
        n_vec++;
        if (n !== 4) begin n_err++; $display("FAIL midrun_period: got %0d want 4", n); end
        idle(2, t);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_vec++;
        if (running !== 1'b0 || phase !== 1'b0 || cpu_tick !== 1'b0) begin
            n_err++; $display("FAIL midrun_reset: got run=%b phase=%b tick=%b want 0/0/0", running, phase, cpu_tick);
        end
        idle(20, t);
        n_vec++;
        if (t !== 0 || running !== 1'b0) begin
            n_err++; $display("FAIL midrun_quiet: got ticks=%0d run=%b want 0/0", t, running);
        end
    endtask

`ifdef CPU_BREAK_EN
    task automatic test_breakpoint();
        int n;
        int t;
        btn_run = 1'b0; btn_step = 1'b0; rate_sel = 3'd0;
        pc = 16'h0010; bkpt_addr = 16'h0010; bkpt_valid = 1'b1;
        idle(10, t);
        btn_run = 1'b1;
        wait_running(1'b1, 20, n, t);
        n_vec++;
        if (n !== 8) begin n_err++; $display("FAIL bkpt_enter: got %0d want 8", n); end
        wait_running(1'b0, 20, n, t);
        n_vec++;
        if (n !== 4 || t !== 0) begin n_err++; $display("FAIL bkpt_stop: got cycles=%0d ticks=%0d want 4/0", n, t); end
        n_vec++;
        if (halted !== 1'b1) begin n_err++; $display("FAIL bkpt_halted: got %b want 1", halted); end
        btn_run = 1'b0;
        idle(10, t);
        btn_step = 1'b1;
        wait_tick(20, n);
        n_vec++;
        if (n !== 8 || halted !== 1'b0 || running !== 1'b0) begin
            n_err++; $display("FAIL bkpt_step: got cycles=%0d halted=%b run=%b want 8/0/0", n, halted, running);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; btn_step = 1'b0; btn_run = 1'b0; rate_sel = 3'd0;
`ifdef CPU_BREAK_EN
        pc = 16'h0000; bkpt_addr = 16'h0000; bkpt_valid = 1'b0;
`endif
        test_reset();
        test_held_through_reset();
        test_bounce();
        test_run_rates();
        test_simultaneous();
        test_reset_mid_run();
`ifdef CPU_BREAK_EN
        test_breakpoint();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
